dual_issue_pair_scheduler: RTL and testbench

//  Decode-to-Execute issue controller for the 2-wide superscalar pipe. Takes a
//  pre-decoded fetch bundle (slot0 older, slot1 younger) and decides each cycle

---
 rtl/dual_issue_pair_scheduler_pkg.sv | 25 ++
 rtl/dual_issue_pair_scheduler_if.sv | 50 +++++
 rtl/dual_issue_pair_scheduler_issue_pair_checker.sv | 31 +++
 rtl/dual_issue_pair_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dual_issue_pair_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dual_issue_pair_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dual_issue_pair_scheduler_pkg
//   Shared definitions for the 2-wide decode-to-execute issue controller.
//   - schedState_t  : FSM state encodings (ISSUE / SPLIT / RECOVER)
//   - ISS_SEL_*     : lane0 source select values
//   - recoverCntWidth: width helper for the post-flush bubble counter
// ---------------------------------------------------------------------------
package dual_issue_pair_scheduler_pkg;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    SPLIT   = 2'd1,
    RECOVER = 2'd2
  } schedState_t;

  // Lane0 operand source: the fetch bundle's slot0, or the held slot1.
  localparam logic ISS_SEL_FETCH = 1'b0;
  localparam logic ISS_SEL_SKID  = 1'b1;

  // Counter must hold RECOVER_CYCLES-1; keep at least one bit.
  function automatic int recoverCntWidth(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/dual_issue_pair_scheduler_if.sv
// ---------------------------------------------------------------------------
// dual_issue_pair_scheduler_if
//   Bundles the fetch-side, hazard-unit and execute-side signals of the
//   pair scheduler.
//   master : fetch / hazard unit side (drives f_*, hz_*; observes results)
//   slave  : the scheduler (consumes f_*, hz_*; drives f_ready, iss_*,
//            redirect_*, st_*)
// ---------------------------------------------------------------------------
interface dual_issue_pair_scheduler_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  // Fetch bundle: slot0 is the older instruction.
  logic             f_valid;
  logic [REG_W-1:0] f_rs0, f_rt0, f_rd0;
  logic [REG_W-1:0] f_rs1, f_rt1, f_rd1;
  logic             f_wr0, f_wr1;
  logic             f_br0, f_br1;
  logic             f_mem0, f_mem1;
  logic             f_ready;

  // Hazard detection unit, lanes 1 and 2.
  logic hz_stall1, hz_stall2;
  logic hz_flush1, hz_flush2;
  logic hz_cpc1, hz_cpc2;

  // Issue into Execute and PC redirect.
  logic iss_v0, iss_v1, iss_sel0;
  logic redirect_v, redirect_lane;

  // Statistics.
  logic [CNT_W-1:0] st_dual, st_split, st_stall;

  modport master (
    output f_valid, f_rs0, f_rt0, f_rd0, f_rs1, f_rt1, f_rd1,
           f_wr0, f_wr1, f_br0, f_br1, f_mem0, f_mem1,
           hz_stall1, hz_stall2, hz_flush1, hz_flush2, hz_cpc1, hz_cpc2,
    input  f_ready, iss_v0, iss_v1, iss_sel0, redirect_v, redirect_lane,
           st_dual, st_split, st_stall
  );

  modport slave (
    input  f_valid, f_rs0, f_rt0, f_rd0, f_rs1, f_rt1, f_rd1,
           f_wr0, f_wr1, f_br0, f_br1, f_mem0, f_mem1,
           hz_stall1, hz_stall2, hz_flush1, hz_flush2, hz_cpc1, hz_cpc2,
    output f_ready, iss_v0, iss_v1, iss_sel0, redirect_v, redirect_lane,
           st_dual, st_split, st_stall
  );

endinterface

// File: rtl/dual_issue_pair_scheduler_issue_pair_checker.sv
// ---------------------------------------------------------------------------
// issue_pair_checker
//   Combinational check of whether an older/younger instruction pair may be
//   issued in the same cycle.
//   Ports:
//     rd0, wr0        older slot destination and write enable
//     rs1, rt1        younger slot sources
//     br0             older slot is a branch (younger is on a predicted path)
//     mem0, mem1      both slots need the single memory port
//     conflict        1 = pair must be split
// ---------------------------------------------------------------------------
module issue_pair_checker #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rd0,
  input  logic             wr0,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rt1,
  input  logic             br0,
  input  logic             mem0,
  input  logic             mem1,
  output logic             conflict
);

  logic rawHazard;

  // Register 0 is hardwired zero, so writing it creates no dependency.
  assign rawHazard = wr0 && (rd0 != '0) && ((rs1 == rd0) || (rt1 == rd0));
  assign conflict  = rawHazard || (mem0 && mem1) || br0;

endmodule

// File: rtl/dual_issue_pair_scheduler.sv
// ---------------------------------------------------------------------------
// dual_issue_pair_scheduler
//   Decode-to-Execute issue controller for the 2-wide pipe. Each cycle it
//   dual-issues the fetch bundle, splits it (slot0 now, slot1 next cycle from
//   the skid), or issues a bubble, honouring stall/flush/correct-PC from the
//   hazard unit.
//   Ports:
//     clk, reset  clock and asynchronous active-high reset
//     bus         dual_issue_pair_scheduler_if.slave (fetch bundle, hazard
//                 inputs, issue/redirect outputs, statistics)
//   Configuration:
//     ISSUE_STATS_EN  when defined, st_dual/st_split/st_stall count
//                     dual-issue cycles, SPLIT entries and stall cycles
//                     (saturating); otherwise they are tied to zero.
//   All outputs are registered except f_ready, which is combinational.
// ---------------------------------------------------------------------------
module dual_issue_pair_scheduler
  import dual_issue_pair_scheduler_pkg::*;
#(
  parameter int REG_W          = 5,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  dual_issue_pair_scheduler_if.slave  bus
);

  localparam int                RCNT_W       = recoverCntWidth(RECOVER_CYCLES);
  localparam logic [RCNT_W-1:0] RECOVER_LOAD = RCNT_W'(RECOVER_CYCLES - 1);

  schedState_t       stateReg;
  logic              skidValidReg;
  logic [RCNT_W-1:0] recoverCntReg;
  logic              issV0Reg, issV1Reg, issSel0Reg;
  logic              redirectVReg, redirectLaneReg;

  logic pairConflict;
  logic anyFlush, anyStall, anyCpc;
  logic dualIssue, splitEntry, stallCycle;
  logic fReady;

  issue_pair_checker #(.REG_W(REG_W)) u_checker (
    .rd0      (bus.f_rd0),
    .wr0      (bus.f_wr0),
    .rs1      (bus.f_rs1),
    .rt1      (bus.f_rt1),
    .br0      (bus.f_br0),
    .mem0     (bus.f_mem0),
    .mem1     (bus.f_mem1),
    .conflict (pairConflict)
  );

  assign anyFlush = bus.hz_flush1 | bus.hz_flush2;
  assign anyStall = bus.hz_stall1 | bus.hz_stall2;
  assign anyCpc   = bus.hz_cpc1   | bus.hz_cpc2;

  // Event qualifiers shared by the FSM and the statistics counters.
  assign stallCycle = !anyFlush && anyStall;
  assign dualIssue  = !anyFlush && !anyStall && (stateReg == ISSUE) &&
                      bus.f_valid && !pairConflict;
  assign splitEntry = !anyFlush && !anyStall && (stateReg == ISSUE) &&
                      bus.f_valid && pairConflict;

  // Fetch advance. During SPLIT the bundle has been held by fetch (f_ready was
  // low), so the skid only tracks occupancy while slot1 is read from the
  // still-presented bundle.
  always_comb begin
    fReady = 1'b0;
    if (anyFlush) begin
      fReady = 1'b1;
    end else if (anyStall) begin
      fReady = 1'b0;
    end else begin
      unique case (stateReg)
        ISSUE:   fReady = bus.f_valid && !pairConflict;
        SPLIT:   fReady = 1'b1;
        RECOVER: fReady = 1'b1;
        default: fReady = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg        <= ISSUE;
      skidValidReg    <= 1'b0;
      recoverCntReg   <= '0;
      issV0Reg        <= 1'b0;
      issV1Reg        <= 1'b0;
      issSel0Reg      <= ISS_SEL_FETCH;
      redirectVReg    <= 1'b0;
      redirectLaneReg <= 1'b0;
    end else begin
      issV0Reg   <= 1'b0;
      issV1Reg   <= 1'b0;
      issSel0Reg <= ISS_SEL_FETCH;

      // Redirect is independent of the issue FSM; lane1 wins a tie.
      redirectVReg    <= anyCpc;
      redirectLaneReg <= !bus.hz_cpc1 && bus.hz_cpc2;

      if (anyFlush) begin
        skidValidReg  <= 1'b0;
        recoverCntReg <= RECOVER_LOAD;
        stateReg      <= RECOVER;
      end else if (anyStall) begin
        // Hold state, skid and recovery count; issue nothing.
      end else begin
        unique case (stateReg)
          ISSUE: begin
            if (bus.f_valid) begin
              issV0Reg <= 1'b1;
              if (pairConflict) begin
                skidValidReg <= 1'b1;
                stateReg     <= SPLIT;
              end else begin
                issV1Reg <= 1'b1;
              end
            end
          end
          SPLIT: begin
            issV0Reg     <= skidValidReg;
            issSel0Reg   <= skidValidReg ? ISS_SEL_SKID : ISS_SEL_FETCH;
            skidValidReg <= 1'b0;
            stateReg     <= ISSUE;
          end
          RECOVER: begin
            if (recoverCntReg == '0) begin
              stateReg <= ISSUE;
            end else begin
              recoverCntReg <= recoverCntReg - 1'b1;
            end
          end
          default: stateReg <= ISSUE;
        endcase
      end
    end
  end

  assign bus.f_ready       = fReady;
  assign bus.iss_v0        = issV0Reg;
  assign bus.iss_v1        = issV1Reg;
  assign bus.iss_sel0      = issSel0Reg;
  assign bus.redirect_v    = redirectVReg;
  assign bus.redirect_lane = redirectLaneReg;

`ifdef ISSUE_STATS_EN
  // Index 0: dual-issue cycles, 1: SPLIT entries, 2: stall cycles.
  logic [2:0]       statInc;
  logic [CNT_W-1:0] statCntReg [3];

  assign statInc = {stallCycle, splitEntry, dualIssue};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        statCntReg[gi] <= '0;
      end else if (statInc[gi] && (statCntReg[gi] != '1)) begin
        statCntReg[gi] <= statCntReg[gi] + 1'b1;
      end
    end
  end

  assign bus.st_dual  = statCntReg[0];
  assign bus.st_split = statCntReg[1];
  assign bus.st_stall = statCntReg[2];
`else
  // Qualifiers are still generated for the FSM; only the counters are absent.
  logic unusedStats;
  assign unusedStats  = stallCycle ^ splitEntry ^ dualIssue;
  assign bus.st_dual  = '0;
  assign bus.st_split = '0;
  assign bus.st_stall = '0;
`endif

endmodule

// File: tb/tb_dual_issue_pair_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dual_issue_pair_scheduler
//   Directed bench for dual_issue_pair_scheduler (RECOVER_CYCLES=2).
//   Statistics expectations follow ISSUE_STATS_EN.
// ---------------------------------------------------------------------------
module tb_dual_issue_pair_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

`ifdef ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  dual_issue_pair_scheduler_if #(.REG_W(5), .CNT_W(32)) bus ();

  dual_issue_pair_scheduler #(
    .REG_W(5), .RECOVER_CYCLES(2), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.f_valid = 1'b0;
    bus.f_rs0 = '0; bus.f_rt0 = '0; bus.f_rd0 = '0;
    bus.f_rs1 = '0; bus.f_rt1 = '0; bus.f_rd1 = '0;
    bus.f_wr0 = 1'b0; bus.f_wr1 = 1'b0;
    bus.f_br0 = 1'b0; bus.f_br1 = 1'b0;
    bus.f_mem0 = 1'b0; bus.f_mem1 = 1'b0;
    bus.hz_stall1 = 1'b0; bus.hz_stall2 = 1'b0;
    bus.hz_flush1 = 1'b0; bus.hz_flush2 = 1'b0;
    bus.hz_cpc1 = 1'b0; bus.hz_cpc2 = 1'b0;
  endtask

  task automatic bundle(input logic [4:0] rs0, rt0, rd0, input logic wr0, br0, mem0,
                        input logic [4:0] rs1, rt1, rd1, input logic wr1, br1, mem1);
    bus.f_valid = 1'b1;
    bus.f_rs0 = rs0; bus.f_rt0 = rt0; bus.f_rd0 = rd0;
    bus.f_wr0 = wr0; bus.f_br0 = br0; bus.f_mem0 = mem0;
    bus.f_rs1 = rs1; bus.f_rt1 = rt1; bus.f_rd1 = rd1;
    bus.f_wr1 = wr1; bus.f_br1 = br1; bus.f_mem1 = mem1;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc=%0d v=%0b s0=(%0d,%0d->%0d w%0b b%0b m%0b) s1=(%0d,%0d->%0d w%0b b%0b m%0b) hz=%0b%0b/%0b%0b/%0b%0b | rdy=%0b iss=%0b%0b sel0=%0b rd=%0b/%0b st=%0d/%0d/%0d",
             cycle, bus.f_valid,
             bus.f_rs0, bus.f_rt0, bus.f_rd0, bus.f_wr0, bus.f_br0, bus.f_mem0,
             bus.f_rs1, bus.f_rt1, bus.f_rd1, bus.f_wr1, bus.f_br1, bus.f_mem1,
             bus.hz_stall1, bus.hz_stall2, bus.hz_flush1, bus.hz_flush2,
             bus.hz_cpc1, bus.hz_cpc2,
             bus.f_ready, bus.iss_v0, bus.iss_v1, bus.iss_sel0,
             bus.redirect_v, bus.redirect_lane,
             bus.st_dual, bus.st_split, bus.st_stall);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_iss_v0", 32'(bus.iss_v0), 0);
    check("rst_iss_v1", 32'(bus.iss_v1), 0);
    check("rst_sel0", 32'(bus.iss_sel0), 0);
    check("rst_redirect_v", 32'(bus.redirect_v), 0);
    check("rst_redirect_lane", 32'(bus.redirect_lane), 0);
    check("rst_f_ready", 32'(bus.f_ready), 0);
    check("rst_st_dual", bus.st_dual, 0);
    check("rst_st_split", bus.st_split, 0);
    check("rst_st_stall", bus.st_stall, 0);
    reset = 1'b0;

    // Independent pair.
    bundle(1, 2, 3, 1, 0, 0, 5, 6, 7, 1, 0, 0);
    #1 check("indep_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("indep_v0", 32'(bus.iss_v0), 1);
    check("indep_v1", 32'(bus.iss_v1), 1);
    check("indep_sel0", 32'(bus.iss_sel0), 0);

    // Writing r0 never creates a dependency.
    bundle(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check("r0_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("r0_v0", 32'(bus.iss_v0), 1);
    check("r0_v1", 32'(bus.iss_v1), 1);

    // One memory op and a younger branch pair fine.
    bundle(8, 9, 10, 1, 0, 1, 11, 12, 13, 1, 1, 0);
    #1 check("mem1only_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("mem1only_v1", 32'(bus.iss_v1), 1);
    check("st_dual_3", bus.st_dual, STATS ? 32'd3 : 32'd0);

    // RAW pair: slot0 now, slot1 from the skid next cycle.
    bundle(1, 2, 4, 1, 0, 0, 4, 7, 9, 1, 0, 0);
    #1 check("raw_f_ready", 32'(bus.f_ready), 0);
    tick();
    check("raw_n_v0", 32'(bus.iss_v0), 1);
    check("raw_n_v1", 32'(bus.iss_v1), 0);
    check("raw_n_sel0", 32'(bus.iss_sel0), 0);
    check("split_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("raw_n1_v0", 32'(bus.iss_v0), 1);
    check("raw_n1_v1", 32'(bus.iss_v1), 0);
    check("raw_n1_sel0", 32'(bus.iss_sel0), 1);
    check("st_split_1", bus.st_split, STATS ? 32'd1 : 32'd0);
    idle();
    #1 check("novalid_f_ready", 32'(bus.f_ready), 0);
    tick();
    check("novalid_v0", 32'(bus.iss_v0), 0);

    // Branch in slot0 splits; stall during SPLIT holds the skid.
    bundle(1, 2, 3, 1, 1, 0, 5, 6, 7, 1, 0, 0);
    tick();
    check("br_v0", 32'(bus.iss_v0), 1);
    check("br_v1", 32'(bus.iss_v1), 0);
    bus.hz_stall1 = 1'b1;
    #1 check("stall_f_ready", 32'(bus.f_ready), 0);
    tick();
    check("stall1_v0", 32'(bus.iss_v0), 0);
    check("stall1_sel0", 32'(bus.iss_sel0), 0);
    tick();
    check("stall2_v0", 32'(bus.iss_v0), 0);
    check("st_stall_2", bus.st_stall, STATS ? 32'd2 : 32'd0);
    bus.hz_stall1 = 1'b0;
    #1 check("unstall_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("unstall_v0", 32'(bus.iss_v0), 1);
    check("unstall_sel0", 32'(bus.iss_sel0), 1);
    check("st_split_2", bus.st_split, STATS ? 32'd2 : 32'd0);

    // Two memory ops split; flush in SPLIT drops skid, 2 bubbles.
    bundle(1, 2, 3, 1, 0, 1, 5, 6, 7, 1, 0, 1);
    #1 check("mem2_f_ready", 32'(bus.f_ready), 0);
    tick();
    check("mem2_v0", 32'(bus.iss_v0), 1);
    bus.hz_flush2 = 1'b1;
    #1 check("flush_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("flush_v0", 32'(bus.iss_v0), 0);
    check("flush_sel0", 32'(bus.iss_sel0), 0);
    bus.hz_flush2 = 1'b0;
    bundle(1, 2, 3, 1, 0, 0, 5, 6, 7, 1, 0, 0);
    #1 check("rec1_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("rec1_v0", 32'(bus.iss_v0), 0);
    check("rec1_v1", 32'(bus.iss_v1), 0);
    check("rec2_f_ready", 32'(bus.f_ready), 1);
    tick();
    check("rec2_v0", 32'(bus.iss_v0), 0);
    check("rec2_v1", 32'(bus.iss_v1), 0);
    tick();
    check("postrec_v0", 32'(bus.iss_v0), 1);
    check("postrec_v1", 32'(bus.iss_v1), 1);
    check("postrec_sel0", 32'(bus.iss_sel0), 0);

    // Correct-PC redirect.
    idle();
    bus.hz_cpc1 = 1'b1;
    bus.hz_cpc2 = 1'b1;
    tick();
    check("cpc_both_v", 32'(bus.redirect_v), 1);
    check("cpc_both_lane", 32'(bus.redirect_lane), 0);
    bus.hz_cpc1 = 1'b0;
    bus.hz_cpc2 = 1'b0;
    tick();
    check("cpc_pulse_end", 32'(bus.redirect_v), 0);
    bus.hz_cpc2 = 1'b1;
    tick();
    check("cpc2_v", 32'(bus.redirect_v), 1);
    check("cpc2_lane", 32'(bus.redirect_lane), 1);
    bus.hz_cpc2 = 1'b0;
    tick();
    check("final_st_dual", bus.st_dual, STATS ? 32'd4 : 32'd0);
    check("final_st_split", bus.st_split, STATS ? 32'd3 : 32'd0);
    check("final_st_stall", bus.st_stall, STATS ? 32'd2 : 32'd0);

    // Asynchronous reset in the middle of SPLIT discards everything.
    bundle(1, 2, 3, 1, 1, 0, 5, 6, 7, 1, 0, 0);
    tick();
    check("presplit_v0", 32'(bus.iss_v0), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_v0", 32'(bus.iss_v0), 0);
    check("midrst_st_dual", bus.st_dual, 0);
    #1 reset = 1'b0;
    idle();
    #1 check("midrst_f_ready", 32'(bus.f_ready), 0);
    bundle(1, 2, 3, 1, 0, 0, 5, 6, 7, 1, 0, 0);
    tick();
    check("afterrst_v0", 32'(bus.iss_v0), 1);
    check("afterrst_v1", 32'(bus.iss_v1), 1);
    check("afterrst_sel0", 32'(bus.iss_sel0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
